// File: rtl/step_motor_sequencer.sv
// -----------------------------------------------------------------------------
// step_motor_sequencer
//
// Drives the four phase lines (AX, AY, BX, BY) of one stepper channel from a
// simple valid/ready command interface. A command carries a direction, a step
// count and a step period in clocks. The block walks an 8-entry phase table at
// the programmed rate, pulses `done` when the move ends (normally or by `stop`)
// and reports whether it was aborted.
//
// Build option:
//   HALF_STEP_EN  - when defined, `cmd_half` selects half-stepping (idx +/-1
//                   over all 8 table entries). When undefined, every move is
//                   full-step, idx stays on odd entries, and no half-step logic
//                   is built.
//
// Parameters:
//   DIV_WIDTH   width of the step period counter
//   STEP_WIDTH  width of the step count
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   cmd_valid   command offered
//   cmd_ready   high only in IDLE; accept = cmd_valid & cmd_ready
//   cmd_dir     1 = forward (idx increases), 0 = reverse
//   cmd_steps   number of steps to issue (0 = finish immediately)
//   cmd_period  clocks per step (0 behaves as 1)
//   cmd_half    half-step request (only with HALF_STEP_EN)
//   hold_en     keep the coils energized while idle
//   stop        abort the move in progress
//   busy        high while stepping
//   done        one-cycle pulse at the end of every move
//   aborted     1 if the last move ended by stop; cleared on next accept
//   steps_left  remaining steps (holds its value after an abort)
//   AX..BY      registered phase outputs
// -----------------------------------------------------------------------------
module step_motor_sequencer #(
    parameter int DIV_WIDTH  = 16,
    parameter int STEP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [STEP_WIDTH-1:0] cmd_steps,
    input  logic [DIV_WIDTH-1:0]  cmd_period,
    input  logic                  cmd_half,
    input  logic                  hold_en,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [STEP_WIDTH-1:0] steps_left,
    output logic                  AX,
    output logic                  AY,
    output logic                  BX,
    output logic                  BY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0]  PERIOD_ONE = DIV_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] STEPS_ONE  = STEP_WIDTH'(1);

    state_t                 state;
    logic [2:0]             idx;
    logic [DIV_WIDTH-1:0]   counter;
    logic [DIV_WIDTH-1:0]   period_q;
    logic                   dir_q;
    logic [3:0]             phase_q;

    logic [DIV_WIDTH-1:0]   eff_period;
    logic [2:0]             step_mag;
    logic [2:0]             idx_next;

`ifdef HALF_STEP_EN
    logic                   half_q;
`else
    // cmd_half has no effect in a full-step-only build.
    logic                   unused_cmd_half;
    assign unused_cmd_half = cmd_half;
`endif

    // Phase table, ordered AX AY BX BY.
    function automatic logic [3:0] phase_of(input logic [2:0] i);
        logic [3:0] p;
        case (i)
            3'd0:    p = 4'b1000;
            3'd1:    p = 4'b1010;
            3'd2:    p = 4'b0010;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0100;
            3'd5:    p = 4'b0101;
            3'd6:    p = 4'b0001;
            3'd7:    p = 4'b1001;
            default: p = 4'b0000;
        endcase
        return p;
    endfunction

    // A zero period is stretched to one clock so the counter always reloads
    // with a value that reaches the tick point.
    assign eff_period = (cmd_period == '0) ? PERIOD_ONE : cmd_period;

    // Index for the next step. A full-step move starting on an even index first
    // lands on the adjacent odd entry; after that it moves in pairs.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        step_mag = 3'd2;
`ifdef HALF_STEP_EN
        if (half_q || !idx[0]) begin
            step_mag = 3'd1;
        end
`endif
        idx_next = dir_q ? (idx + step_mag) : (idx - step_mag);
    end

    assign {AX, AY, BX, BY} = phase_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state      <= S_IDLE;
            idx        <= 3'd1;
            counter    <= '0;
            period_q   <= '0;
            dir_q      <= 1'b0;
            steps_left <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            cmd_ready  <= 1'b1;
            phase_q    <= 4'b0000;
`ifdef HALF_STEP_EN
            half_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        steps_left <= cmd_steps;
                        counter    <= eff_period;
                        period_q   <= eff_period;
                        dir_q      <= cmd_dir;
`ifdef HALF_STEP_EN
                        half_q     <= cmd_half;
`endif
                        aborted    <= 1'b0;
                        cmd_ready  <= 1'b0;
                        // Coils are energized for the whole move, even if
                        // hold_en had them coasting while idle.
                        phase_q    <= phase_of(idx);
                        if (cmd_steps == '0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        phase_q <= hold_en ? phase_of(idx) : 4'b0000;
                    end
                end

                S_RUN: begin
                    if (stop) begin
                        // Abort beats a coincident tick: no step is taken and
                        // steps_left keeps its value.
                        state   <= S_FIN;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (counter <= PERIOD_ONE) begin
                        idx     <= idx_next;
                        phase_q <= phase_of(idx_next);
                        counter <= period_q;
                        if (steps_left != '0) begin
                            steps_left <= steps_left - STEPS_ONE;
                        end
                        if (steps_left <= STEPS_ONE) begin
                            state <= S_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        counter <= counter - PERIOD_ONE;
                    end
                end

                S_FIN: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    phase_q   <= hold_en ? phase_of(idx) : 4'b0000;
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    phase_q   <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_motor_sequencer.sv
// -----------------------------------------------------------------------------
// tb_step_motor_sequencer
//
// Directed bench for step_motor_sequencer. Inputs change 1 time unit after a
// rising edge; outputs are sampled on the falling edge. "Cycle n" below is the
// n-th falling edge after the accepting rising edge, so a register updated on
// rising edge k+j is seen in cycle j+1.
// -----------------------------------------------------------------------------
module tb_step_motor_sequencer;

    localparam int DW = 16;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_dir = 1'b0;
    logic [SW-1:0] cmd_steps = '0;
    logic [DW-1:0] cmd_period = '0;
    logic          cmd_half = 1'b0;
    logic          hold_en = 1'b0;
    logic          stop = 1'b0;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [SW-1:0] steps_left;
    logic          AX, AY, BX, BY;
    logic [3:0]    phase;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected phases for a 4-step, period-3 move from idx 1, cycles 1..14.
    logic [3:0] exp_fwd [14] = '{
        4'b1010, 4'b1010, 4'b1010,
        4'b0110, 4'b0110, 4'b0110,
        4'b0101, 4'b0101, 4'b0101,
        4'b1001, 4'b1001, 4'b1001,
        4'b1010, 4'b0000
    };
    logic [3:0] exp_rev [14] = '{
        4'b1010, 4'b1010, 4'b1010,
        4'b1001, 4'b1001, 4'b1001,
        4'b0101, 4'b0101, 4'b0101,
        4'b0110, 4'b0110, 4'b0110,
        4'b1010, 4'b1010
    };

    step_motor_sequencer #(
        .DIV_WIDTH (DW),
        .STEP_WIDTH(SW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .cmd_period(cmd_period),
        .cmd_half  (cmd_half),
        .hold_en   (hold_en),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .steps_left(steps_left),
        .AX        (AX),
        .AY        (AY),
        .BX        (BX),
        .BY        (BY)
    );

    assign phase = {AX, AY, BX, BY};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; the command is accepted on the next rising edge.
    task automatic send(input logic dir, input logic [SW-1:0] steps,
                        input logic [DW-1:0] period, input logic half);
        check("ready before accept", 32'(cmd_ready), 32'd1);
        cmd_dir    = dir;
        cmd_steps  = steps;
        cmd_period = period;
        cmd_half   = half;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic expect_cycle(input string tag, input int n, input logic [3:0] ph,
                                input logic b, input logic d);
        @(negedge clk);
        check($sformatf("%s c%0d phase", tag, n), 32'(phase), 32'(ph));
        check($sformatf("%s c%0d busy", tag, n), 32'(busy), 32'(b));
        check($sformatf("%s c%0d done", tag, n), 32'(done), 32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset values ----------------
        #12;
        check("rst phase", 32'(phase), 32'h0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst aborted", 32'(aborted), 32'd0);
        check("rst ready", 32'(cmd_ready), 32'd1);
        check("rst steps_left", 32'(steps_left), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle coast phase", 32'(phase), 32'h0);

        // ---------------- forward full-step, coast when idle ----------------
        send(1'b1, 16'd4, 16'd3, 1'b0);
        for (int n = 1; n <= 14; n++) begin
            expect_cycle("fwd", n, exp_fwd[n-1], n <= 12, n == 13);
        end
        check("fwd ready after", 32'(cmd_ready), 32'd1);
        check("fwd aborted", 32'(aborted), 32'd0);
        check("fwd steps_left", 32'(steps_left), 32'd0);

        // ---------------- reverse full-step, hold when idle ----------------
        hold_en = 1'b1;
        send(1'b0, 16'd4, 16'd3, 1'b0);
        for (int n = 1; n <= 14; n++) begin
            expect_cycle("rev", n, exp_rev[n-1], n <= 12, n == 13);
        end

`ifdef HALF_STEP_EN
        // ---------------- half-step then full-step alignment ----------------
        send(1'b1, 16'd3, 16'd1, 1'b1);
        expect_cycle("half", 1, 4'b1010, 1'b1, 1'b0);
        expect_cycle("half", 2, 4'b0010, 1'b1, 1'b0);
        expect_cycle("half", 3, 4'b0110, 1'b1, 1'b0);
        expect_cycle("half", 4, 4'b0100, 1'b0, 1'b1);
        expect_cycle("half", 5, 4'b0100, 1'b0, 1'b0);
        send(1'b1, 16'd1, 16'd1, 1'b0);
        expect_cycle("align", 1, 4'b0100, 1'b1, 1'b0);
        expect_cycle("align", 2, 4'b0101, 1'b0, 1'b1);
        expect_cycle("align", 3, 4'b0101, 1'b0, 1'b0);
`endif

        // ---------------- reset in the middle of a move ----------------
        send(1'b1, 16'd10, 16'd2, 1'b0);
        repeat (5) @(negedge clk);
        check("mid busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async rst phase", 32'(phase), 32'h0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst ready", 32'(cmd_ready), 32'd1);
        check("async rst steps_left", 32'(steps_left), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("post rst idx1 hold phase", 32'(phase), 32'hA);
        check("post rst ready", 32'(cmd_ready), 32'd1);
        check("post rst steps_left", 32'(steps_left), 32'd0);

        // ---------------- stop coinciding with the 3rd tick ----------------
        send(1'b1, 16'd10, 16'd5, 1'b0);
        repeat (15) @(negedge clk);
        check("stop pre steps_left", 32'(steps_left), 32'd8);
        check("stop pre phase", 32'(phase), 32'h5);
        check("stop pre busy", 32'(busy), 32'd1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop done", 32'(done), 32'd1);
        check("stop aborted", 32'(aborted), 32'd1);
        check("stop steps_left", 32'(steps_left), 32'd8);
        check("stop phase", 32'(phase), 32'h5);
        check("stop busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("stop after done", 32'(done), 32'd0);
        check("stop after ready", 32'(cmd_ready), 32'd1);
        check("stop aborted held", 32'(aborted), 32'd1);
        // stop while idle has no effect
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("idle stop ready", 32'(cmd_ready), 32'd1);
        check("idle stop done", 32'(done), 32'd0);
        check("idle stop busy", 32'(busy), 32'd0);

        // ---------------- zero steps, zero period ----------------
        send(1'b1, 16'd0, 16'd0, 1'b0);
        expect_cycle("zero", 1, 4'b0101, 1'b0, 1'b1);
        check("zero aborted", 32'(aborted), 32'd0);
        check("zero ready", 32'(cmd_ready), 32'd0);
        check("zero steps_left", 32'(steps_left), 32'd0);
        expect_cycle("zero", 2, 4'b0101, 1'b0, 1'b0);
        check("zero ready back", 32'(cmd_ready), 32'd1);

        // ---------------- zero period, two steps ----------------
        send(1'b1, 16'd2, 16'd0, 1'b0);
        expect_cycle("p0", 1, 4'b0101, 1'b1, 1'b0);
        expect_cycle("p0", 2, 4'b1001, 1'b1, 1'b0);
        expect_cycle("p0", 3, 4'b1010, 1'b0, 1'b1);
        expect_cycle("p0", 4, 4'b1010, 1'b0, 1'b0);
        check("p0 ready", 32'(cmd_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
